sample_demux: RTL
=================

# sample_demux

Serial-to-parallel distributor for the 32-point FFT datapath. It accepts one complex sample per handshake and steers consecutive samples into four output lanes, OUT0 through OUT3. When the fourth lane fills, it presents the group of four in parallel. It sits ahead of the radix stages and is the inverse of the 4:1 lane selector at the stage outputs. It also tracks group position within a 32-sample frame and flags the last group.

## Interface
- fix_bit, 7: fractional bit count of each real/imag half. Carried for datapath consistency; the block does not interpret data.
- bits, 16: width of each real/imag half. A sample is 2*bits wide, {real, imag}.
- CLK  in  1  sole clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- IN  in  2*bits  input sample.
- IN_VALID  in  1  IN holds a sample.
- IN_READY  out  1  block can accept IN this cycle.
- FRAME_SYNC  in  1  restart frame alignment; the sample accepted in the same cycle becomes lane 0 of group 0.
- OUT0..OUT3  out  2*bits each  parallel group; OUT0 holds the earliest sample.
- OUT_VALID  out  1  OUT0..OUT3 hold a complete group.
- OUT_READY  in  1  downstream accepts the group.
- OUT_LAST  out  1  the presented group is group 7, the last of the frame.
- LANE  out  2  lane that the next accepted sample will fill.
- GROUP  out  3  index of the group currently being collected.
- FRAME_DONE  out  1  one-cycle pulse after the last group of a frame is handed off.

## Operation
- Accept: a sample is accepted on a cycle where IN_VALID && IN_READY.
- Collect buffer: three registers hold lanes 0–2.
- Output register: a separate register holds OUT0..OUT3 and OUT_LAST, so the block is double-buffered.
- Lanes 0–2: an accepted sample is written to collect[LANE], then LANE increments.
- Lane 3: the accepted sample loads the output register with {collect0, collect1, collect2, IN}.
  - OUT_VALID is set.
  - OUT_LAST is set to (GROUP==7).
  - LANE wraps to 0.
  - GROUP increments mod 8 (7 wraps to 0).
- Output handshake: OUT_VALID && OUT_READY clears OUT_VALID, unless a new group loads in the same cycle, in which case OUT_VALID stays 1 with the new data.
- Backpressure: IN_READY = !(LANE==3 && OUT_VALID && !OUT_READY).
  - This is a combinational path from OUT_READY.
  - Lanes 0–2 are always accepted.
- FRAME_DONE: pulses for one cycle on the cycle after an output handshake that retires a group with OUT_LAST=1.
- FRAME_SYNC handling:
  - On any cycle with FRAME_SYNC=1, LANE and GROUP are forced to 0 and the partial collect buffer is discarded.
  - If a sample is also accepted that cycle, it is written to lane 0 and LANE becomes 1.
  - The output register and OUT_VALID are not affected, so a pending group is still delivered.
  - FRAME_SYNC with LANE==3 and a blocked output: the sample is accepted, because IN_READY is computed from the pre-sync LANE only when FRAME_SYNC=0. With FRAME_SYNC=1, IN_READY=1.
- Reset: clears OUT0..OUT3, OUT_VALID, OUT_LAST, FRAME_DONE, LANE and GROUP to 0, and clears the collect buffer. IN_READY=1 during and after reset.
  - Reset mid-frame discards all held data.
  - RST has priority over FRAME_SYNC and both handshakes.
- No arithmetic on data: samples pass bit-exact. No width change.

## Timing
- Latency: the last sample of a group is accepted at edge N; OUT0..OUT3 are valid after edge N.
- Throughput: one sample per cycle sustained when OUT_READY=1, giving one group every 4 cycles.
- Stall at LANE==3 with the output full: IN_READY falls in the same cycle that OUT_READY is low. Acceptance resumes in the cycle OUT_READY rises, with simultaneous unload and load.
- Output stability: OUT0..OUT3 and OUT_LAST hold stable while OUT_VALID && !OUT_READY.
- FRAME_DONE: registered, one cycle wide, one cycle after the retiring handshake.
- LANE and GROUP: registered, updated at the accepting edge.

## Test plan
- Reset then stream 0x00010000..0x00040000 with OUT_READY=1.
  - Required: OUT0..OUT3 equal those four values one cycle after the 4th accept, OUT_VALID=1, GROUP=1, LANE=0.
- Full frame of 32 samples, values 0..31, with OUT_READY=1.
  - Required: eight groups, {0,1,2,3} through {28,29,30,31}.
  - Required: OUT_LAST=1 only on {28..31}, FRAME_DONE a single pulse one cycle after that handshake, GROUP back at 0.
- Hold OUT_READY=0 after the first group and keep IN_VALID=1.
  - Required: samples 4,5,6 are accepted, then IN_READY=0 at LANE=3, and OUT0 stays 0.
  - Then raise OUT_READY: sample 7 is accepted that cycle and OUT becomes {4,5,6,7} with OUT_VALID continuously 1.
- After 2 accepted samples, assert FRAME_SYNC with IN=0xAAAA5555.
  - Required: LANE=1, GROUP=0, and the next group is {0xAAAA5555, s1, s2, s3}. The discarded samples never appear on OUT.
- Assert RST mid-group, after 3 samples, with OUT_VALID=1.
  - Required: next cycle all outputs are 0, IN_READY=1, and the following 4 samples form group 0 cleanly.
- Random IN_VALID/OUT_READY toggling over 4 frames.
  - Required: the output sequence equals the input sequence in order with no loss or duplication, and OUT_LAST appears every 8th group.

Source files
------------

// File: rtl/sample_demux.sv
// sample_demux: steers a serial stream of complex samples into four parallel
// lanes. Lanes 0-2 wait in a collect buffer. The fourth sample loads a separate
// output register together with them, so collection continues while a group
// waits downstream. The block also tracks the group index within a 32-sample
// frame (eight groups of four).
module sample_demux #(
  parameter int fix_bit = 7,
  parameter int bits    = 16
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [2*bits-1:0]   IN,
  input  logic                IN_VALID,
  output logic                IN_READY,
  input  logic                FRAME_SYNC,
  output logic [2*bits-1:0]   OUT0,
  output logic [2*bits-1:0]   OUT1,
  output logic [2*bits-1:0]   OUT2,
  output logic [2*bits-1:0]   OUT3,
  output logic                OUT_VALID,
  input  logic                OUT_READY,
  output logic                OUT_LAST,
  output logic [1:0]          LANE,
  output logic [2:0]          GROUP,
  output logic                FRAME_DONE
);

  localparam int W = 2 * bits;

  // The fractional position is only meaningful if it lies inside a half-word.
  if (fix_bit >= bits) begin : g_fix_bit_range
    $error("sample_demux: fix_bit must be smaller than bits");
  end

  logic [1:0]   lane_p0;
  logic [2:0]   group_p0;
  logic [W-1:0] collect0_p0;
  logic [W-1:0] collect1_p0;
  logic [W-1:0] collect2_p0;

  logic [W-1:0] out0_p1;
  logic [W-1:0] out1_p1;
  logic [W-1:0] out2_p1;
  logic [W-1:0] out3_p1;
  logic         vld_p1;
  logic         last_p1;

  logic         done_p2;

  logic [1:0]   lane_eff;
  logic [2:0]   group_eff;
  logic         accept;
  logic         load;
  logic         retire;

  // FRAME_SYNC realigns the sample taken in the same cycle to lane 0 of group 0.
  assign lane_eff  = FRAME_SYNC ? 2'd0 : lane_p0;
  assign group_eff = FRAME_SYNC ? 3'd0 : group_p0;

  // Only a lane-3 sample can be blocked. A sync always lands in lane 0, so it
  // is never blocked.
  assign IN_READY = FRAME_SYNC || !((lane_p0 == 2'd3) && vld_p1 && !OUT_READY);
  assign accept   = IN_VALID && IN_READY;
  assign load     = accept && (lane_eff == 2'd3);
  assign retire   = vld_p1 && OUT_READY;

  // ---- stage p0: collect buffer and lane/group position ----

  // Capture lanes 0-2. A sync discards the partial group.
  always_ff @(posedge CLK) begin
    if (RST) begin
      collect0_p0 <= '0;
      collect1_p0 <= '0;
      collect2_p0 <= '0;
    end else begin
      if (FRAME_SYNC) begin
        collect0_p0 <= '0;
        collect1_p0 <= '0;
        collect2_p0 <= '0;
      end
      if (accept) begin
        case (lane_eff)
          2'd0:    collect0_p0 <= IN;
          2'd1:    collect1_p0 <= IN;
          2'd2:    collect2_p0 <= IN;
          default: ;
        endcase
      end
    end
  end

  // Advance the lane on every accept. Advance the group when lane 3 completes it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      lane_p0  <= 2'd0;
      group_p0 <= 3'd0;
    end else if (accept) begin
      if (load) begin
        lane_p0  <= 2'd0;
        group_p0 <= group_eff + 3'd1;
      end else begin
        lane_p0  <= lane_eff + 2'd1;
        group_p0 <= group_eff;
      end
    end else if (FRAME_SYNC) begin
      lane_p0  <= 2'd0;
      group_p0 <= 3'd0;
    end
  end

  // ---- stage p1: output register ----

  // Load a completed group. It holds until downstream takes it.
  // A load in the same cycle as a retire keeps OUT_VALID high.
  always_ff @(posedge CLK) begin
    if (RST) begin
      out0_p1 <= '0;
      out1_p1 <= '0;
      out2_p1 <= '0;
      out3_p1 <= '0;
      last_p1 <= 1'b0;
      vld_p1  <= 1'b0;
    end else if (load) begin
      out0_p1 <= collect0_p0;
      out1_p1 <= collect1_p0;
      out2_p1 <= collect2_p0;
      out3_p1 <= IN;
      last_p1 <= (group_eff == 3'd7);
      vld_p1  <= 1'b1;
    end else if (retire) begin
      vld_p1  <= 1'b0;
    end
  end

  // ---- stage p2: frame completion flag ----

  // Pulse once after the last group of a frame has been handed off.
  always_ff @(posedge CLK) begin
    if (RST) begin
      done_p2 <= 1'b0;
    end else begin
      done_p2 <= retire && last_p1;
    end
  end

  assign OUT0       = out0_p1;
  assign OUT1       = out1_p1;
  assign OUT2       = out2_p1;
  assign OUT3       = out3_p1;
  assign OUT_VALID  = vld_p1;
  assign OUT_LAST   = last_p1;
  assign LANE       = lane_p0;
  assign GROUP      = group_p0;
  assign FRAME_DONE = done_p2;

endmodule
